// File: rtl/mem_access_seq.sv
// Purpose : SRAM access sequencer between MAR/MDR and an external 16-bit async SRAM.
// Latency : read done at E0+WAIT_CYCLES+1, write done at E0+WAIT_CYCLES+3 (E0 = cycle start is presented).
// Backpres: start_rd/start_wr are sampled only while idle (busy=0); requests seen while busy are ignored.
//
// Ports:
//   Clk, Reset            clock and synchronous active-high reset
//   start_rd, start_wr    access requests (read wins when both are high)
//   addr, wdata           MAR / MDR values, latched at the accept edge
//   sram_din              data returned by the SRAM
//   sram_addr, sram_dout  SRAM address and write data (registered)
//   sram_drive            tristate enable for sram_dout (1 = FPGA drives the bus)
//   sram_ce_n/oe_n/we_n   SRAM strobes, active low
//   mdr_data, mdr_load    captured read data and its one-cycle MDR load strobe
//   busy, done            non-idle indicator and one-cycle completion pulse
//   sw_in, hex_out        only with MEM_IO_MAP_EN: address all-ones maps to switches / display
//
// Optional feature macro: MEM_IO_MAP_EN

module mem_access_seq #(
  parameter int N           = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start_rd,
  input  logic         start_wr,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] wdata,
  input  logic [N-1:0] sram_din,
`ifdef MEM_IO_MAP_EN
  input  logic [N-1:0] sw_in,
  output logic [N-1:0] hex_out,
`endif
  output logic [N-1:0] sram_addr,
  output logic [N-1:0] sram_dout,
  output logic         sram_drive,
  output logic         sram_ce_n,
  output logic         sram_oe_n,
  output logic         sram_we_n,
  output logic [N-1:0] mdr_data,
  output logic         mdr_load,
  output logic         busy,
  output logic         done
);

  // The wait counter is 4 bits wide, so only 1..15 wait states are meaningful.
  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
    $error("mem_access_seq: WAIT_CYCLES must be in 1..15");
  end

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

`ifdef MEM_IO_MAP_EN
  localparam logic [N-1:0] IO_ADDR = {N{1'b1}};
`endif

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] cnt;

  // Every output is a flop; each transition loads the output values that
  // belong to the state being entered, so strobes change cleanly on edges.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      sram_drive <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      mdr_data   <= '0;
      mdr_load   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef MEM_IO_MAP_EN
      hex_out    <= '0;
`endif
    end else begin
      // Pulses default low; only the transition into DONE raises them.
      done     <= 1'b0;
      mdr_load <= 1'b0;

      case (state)
        IDLE: begin
          if (start_rd) begin
            sram_addr <= addr;
`ifdef MEM_IO_MAP_EN
            if (addr == IO_ADDR) begin
              // I/O-mapped read: switches go straight to the MDR, SRAM untouched.
              mdr_data <= sw_in;
              mdr_load <= 1'b1;
              done     <= 1'b1;
              busy     <= 1'b1;
              state    <= DONE;
            end else
`endif
            begin
              cnt        <= CNT_INIT;
              sram_ce_n  <= 1'b0;
              sram_oe_n  <= 1'b0;
              sram_we_n  <= 1'b1;
              sram_drive <= 1'b0;
              busy       <= 1'b1;
              state      <= RD_WAIT;
            end
          end else if (start_wr) begin
            sram_addr <= addr;
`ifdef MEM_IO_MAP_EN
            if (addr == IO_ADDR) begin
              // I/O-mapped write: data goes to the display register only.
              hex_out <= wdata;
              done    <= 1'b1;
              busy    <= 1'b1;
              state   <= DONE;
            end else
`endif
            begin
              sram_dout  <= wdata;
              sram_ce_n  <= 1'b0;
              sram_oe_n  <= 1'b1;
              sram_we_n  <= 1'b1;
              sram_drive <= 1'b1;
              busy       <= 1'b1;
              state      <= WR_SETUP;
            end
          end
        end

        RD_WAIT: begin
          if (cnt == 4'd0) begin
            // Last wait state: sram_din is settled, capture it on this edge.
            mdr_data   <= sram_din;
            mdr_load   <= 1'b1;
            done       <= 1'b1;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_drive <= 1'b0;
            state      <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        WR_SETUP: begin
          // Address and data have been stable for one cycle; open the write pulse.
          cnt       <= CNT_INIT;
          sram_we_n <= 1'b0;
          state     <= WR_PULSE;
        end

        WR_PULSE: begin
          if (cnt == 4'd0) begin
            // Raise we_n but keep ce_n, data and drive for one hold cycle.
            sram_we_n <= 1'b1;
            state     <= WR_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end

        WR_HOLD: begin
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_drive <= 1'b0;
          done       <= 1'b1;
          state      <= DONE;
        end

        DONE: begin
          // No start sampling here: that guarantees one idle cycle between accesses.
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          sram_ce_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_drive <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
module tb_mem_access_seq;

  localparam int N = 16;
  localparam int W = 2;

`ifdef MEM_IO_MAP_EN
  localparam bit             IO_EN   = 1'b1;
  localparam logic [N-1:0]   RD_FFFF = 16'h00C3;   // switches
`else
  localparam bit             IO_EN   = 1'b0;
  localparam logic [N-1:0]   RD_FFFF = 16'h0042;   // ordinary SRAM word written earlier
`endif

  logic         Clk = 1'b0;
  logic         Reset;
  logic         start_rd, start_wr;
  logic [N-1:0] addr, wdata;
  logic [N-1:0] sram_din = '0;
  logic [N-1:0] sram_addr, sram_dout, mdr_data;
  logic         sram_drive, sram_ce_n, sram_oe_n, sram_we_n, mdr_load, busy, done;
`ifdef MEM_IO_MAP_EN
  logic [N-1:0] sw_in, hex_out;
`endif

  mem_access_seq #(.N(N), .WAIT_CYCLES(W)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .start_rd   (start_rd),
    .start_wr   (start_wr),
    .addr       (addr),
    .wdata      (wdata),
    .sram_din   (sram_din),
`ifdef MEM_IO_MAP_EN
    .sw_in      (sw_in),
    .hex_out    (hex_out),
`endif
    .sram_addr  (sram_addr),
    .sram_dout  (sram_dout),
    .sram_drive (sram_drive),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .mdr_data   (mdr_data),
    .mdr_load   (mdr_load),
    .busy       (busy),
    .done       (done)
  );

  always #5 Clk = ~Clk;

  // cyc = number of rising edges so far; a "cycle k" is the interval after edge k.
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    int           e0;      // cycle in which the request was presented
    int           lat;
    logic         rd;
    int           ce_cyc;
    int           oe_cyc;
    int           we_cyc;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] mdr;
  } exp_t;

  exp_t sb[$];

  function automatic logic is_io(input logic [N-1:0] a);
    return IO_EN && (a == 16'hFFFF);
  endfunction

  function automatic void push(input int e0, input logic rd, input logic [N-1:0] a,
                               input logic [N-1:0] d, input logic [N-1:0] mdr);
    exp_t e;
    logic io;
    io       = is_io(a);
    e.e0     = e0;
    e.rd     = rd;
    e.addr   = a;
    e.wdata  = d;
    e.mdr    = mdr;
    e.lat    = io ? 1 : (rd ? W + 1 : W + 3);
    e.ce_cyc = io ? 0 : (rd ? W : W + 2);
    e.oe_cyc = (!io && rd) ? W : 0;
    e.we_cyc = (!io && !rd) ? W : 0;
    sb.push_back(e);
  endfunction

  // ---------------- SRAM model + monitor ----------------
  logic [N-1:0] mem [logic [N-1:0]];

  function automatic logic [N-1:0] mem_rd(input logic [N-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'hACDB;   // unwritten words: 0x1234 reads back as 0xBEEF
  endfunction

  int   ce_cnt = 0, oe_cnt = 0, we_cnt = 0;
  logic ce_prev = 1'b1;
  int   done_cycles[$];
  int   fall_cycles[$];
  exp_t mon_e;

  always @(negedge Clk) begin
    if (Reset) begin
      ce_cnt = 0;
      oe_cnt = 0;
      we_cnt = 0;
    end else begin
      chk("we_oe_exclusive", 32'(!sram_we_n && !sram_oe_n), 32'd0);
      chk("no_drive_while_oe", 32'(!sram_oe_n && sram_drive), 32'd0);
      if (!sram_ce_n) ce_cnt++;
      if (!sram_oe_n) oe_cnt++;
      if (!sram_we_n) we_cnt++;
      if (!sram_ce_n && ce_prev) fall_cycles.push_back(cyc);
      if (!sram_ce_n && sb.size() > 0) begin
        chk("sram_addr", 32'(sram_addr), 32'(sb[0].addr));
        if (!sb[0].rd) begin
          chk("sram_dout", 32'(sram_dout), 32'(sb[0].wdata));
          chk("drive_in_write", 32'(sram_drive), 32'd1);
        end
      end
      if (!sram_ce_n && !sram_we_n && sram_drive) mem[sram_addr] = sram_dout;
      sram_din = (!sram_ce_n && !sram_oe_n) ? mem_rd(sram_addr) : '0;

      if (done) begin
        done_cycles.push_back(cyc);
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: got done=1 with no access outstanding (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("latency", 32'(cyc - mon_e.e0), 32'(mon_e.lat));
          chk("mdr_load", 32'(mdr_load), 32'(mon_e.rd));
          chk("mdr_data", 32'(mdr_data), 32'(mon_e.mdr));
          chk("ce_low_cycles", 32'(ce_cnt), 32'(mon_e.ce_cyc));
          chk("oe_low_cycles", 32'(oe_cnt), 32'(mon_e.oe_cyc));
          chk("we_low_cycles", 32'(we_cnt), 32'(mon_e.we_cyc));
        end
        ce_cnt = 0;
        oe_cnt = 0;
        we_cnt = 0;
      end else begin
        chk("mdr_load_without_done", 32'(mdr_load), 32'd0);
      end
    end
    ce_prev = sram_ce_n;
  end

  // ---------------- driver helpers ----------------
  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(posedge Clk); #3;
      k++;
    end while (!(busy == 1'b0 && done == 1'b0 && sb.size() == 0) && k < 200);
    chk("idle_reached", 32'(busy == 1'b0 && sb.size() == 0), 32'd1);
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [N-1:0] a,
                       input logic [N-1:0] d, input logic [N-1:0] mdr);
    start_rd = rd;
    start_wr = wr;
    addr     = a;
    wdata    = d;
    push(cyc, rd, a, d, mdr);
    @(posedge Clk); #3;
    start_rd = 1'b0;
    start_wr = 1'b0;
    // Scramble inputs while busy: the latched values must be used.
    addr     = N'($urandom_range(16'hFFFE, 0));
    wdata    = N'($urandom);
  endtask

  typedef struct {
    logic         rd;
    logic         wr;
    logic [N-1:0] addr;
    logic [N-1:0] wdata;
    logic [N-1:0] mdr;    // mdr_data expected at done (held value for writes)
  } vec_t;

  vec_t vt[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c;
    int nreads;

    vt[0] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'hBEEF};
    vt[1] = '{1'b0, 1'b1, 16'h00A0, 16'h5A5A, 16'hBEEF};
    vt[2] = '{1'b1, 1'b1, 16'h00A0, 16'h1111, 16'h5A5A};  // read wins, write dropped
    vt[3] = '{1'b1, 1'b0, 16'h00A0, 16'h0000, 16'h5A5A};
    vt[4] = '{1'b0, 1'b1, 16'h8001, 16'hFFFF, 16'h5A5A};
    vt[5] = '{1'b1, 1'b0, 16'h8001, 16'h0000, 16'hFFFF};
    vt[6] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 16'hACDB};
    vt[7] = '{1'b0, 1'b1, 16'hFFFF, 16'h0042, 16'hACDB};
    vt[8] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, RD_FFFF};

    Reset    = 1'b1;
    start_rd = 1'b0;
    start_wr = 1'b0;
    addr     = '0;
    wdata    = '0;
`ifdef MEM_IO_MAP_EN
    sw_in    = 16'h00C3;
`endif
    repeat (3) @(posedge Clk);
    #3 Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #3;

    // Reset / idle state
    chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("rst_we_n", 32'(sram_we_n), 32'd1);
    chk("rst_drive", 32'(sram_drive), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_mdr_load", 32'(mdr_load), 32'd0);
    chk("rst_mdr_data", 32'(mdr_data), 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_dout", 32'(sram_dout), 32'd0);
`ifdef MEM_IO_MAP_EN
    chk("rst_hex_out", 32'(hex_out), 32'd0);
`endif

    // Table-driven accesses
    for (int i = 0; i < 9; i++) begin
      wait_idle();
      issue(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wdata, vt[i].mdr);
    end
    wait_idle();
`ifdef MEM_IO_MAP_EN
    chk("hex_out", 32'(hex_out), 32'h0042);
`endif

    // Back-to-back: both starts high, then start_rd held for 10 cycles
    done_cycles.delete();
    fall_cycles.delete();
    c        = cyc;
    start_rd = 1'b1;
    start_wr = 1'b1;
    addr     = 16'h00A0;
    wdata    = 16'h7777;
    nreads   = 0;
    for (int k = 0; k * (W + 2) <= 9; k++) begin
      push(c + k * (W + 2), 1'b1, 16'h00A0, 16'h7777, 16'h5A5A);
      nreads++;
    end
    @(posedge Clk); #3;
    start_wr = 1'b0;
    repeat (9) begin
      @(posedge Clk); #3;
    end
    start_rd = 1'b0;
    wait_idle();
    chk("b2b_done_count", 32'(done_cycles.size()), 32'(nreads));
    chk("b2b_ce_fall_count", 32'(fall_cycles.size()), 32'(nreads));
    for (int k = 1; k < nreads; k++) begin
      if (k < fall_cycles.size() && k - 1 < done_cycles.size())
        chk("b2b_idle_gap", 32'(fall_cycles[k] - done_cycles[k-1]), 32'd2);
    end

    // Reset in the second WR_PULSE cycle aborts the write with no done
    wait_idle();
    start_wr = 1'b1;
    addr     = 16'h3000;
    wdata    = 16'hDEAD;
    @(posedge Clk); #3;          // WR_SETUP
    start_wr = 1'b0;
    @(posedge Clk); #3;          // WR_PULSE 1
    @(posedge Clk); #3;          // WR_PULSE 2
    chk("abort_in_pulse_we_n", 32'(sram_we_n), 32'd0);
    Reset = 1'b1;
    @(posedge Clk); #3;
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_ce_n", 32'(sram_ce_n), 32'd1);
    chk("abort_drive", 32'(sram_drive), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    Reset = 1'b0;
    repeat (6) begin
      @(posedge Clk); #3;
      chk("abort_no_done", 32'(done), 32'd0);
    end

    // Reset has priority over start in the same cycle
    wait_idle();
    start_rd = 1'b1;
    addr     = 16'h1234;
    Reset    = 1'b1;
    @(posedge Clk); #3;
    chk("prio_busy", 32'(busy), 32'd0);
    chk("prio_ce_n", 32'(sram_ce_n), 32'd1);
    chk("prio_mdr_data", 32'(mdr_data), 32'd0);
`ifdef MEM_IO_MAP_EN
    chk("prio_hex_out", 32'(hex_out), 32'd0);
`endif
    Reset    = 1'b0;
    start_rd = 1'b0;
    repeat (3) begin
      @(posedge Clk); #3;
      chk("prio_stays_idle", 32'(busy), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- SRAM access sequencer between the MAR/MDR registers and the external 16-bit SRAM.
- Takes a latched address and write data, and runs a fixed-wait-state read or write cycle on the SRAM strobes.
- Returns read data with a one-cycle load strobe that drives the MDR register's load_enable.
- Asserts a one-cycle done (memory-ready) pulse to the control FSM.

Parameters:
- N, 16: address and data width.
- WAIT_CYCLES, 2: SRAM access wait states. Legal range 1..15. A value of 0 fails an elaboration-time assertion.

Ports:
- Clk  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- start_rd  in  1  request read; sampled only in IDLE.
- start_wr  in  1  request write; sampled only in IDLE.
- addr  in  N  access address (MAR output).
- wdata  in  N  write data (MDR output).
- sram_din  in  N  data returned by SRAM.
- sram_addr  out  N  SRAM address.
- sram_dout  out  N  data driven to SRAM.
- sram_drive  out  1  tristate enable for sram_dout (high = FPGA drives bus).
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.
- mdr_data  out  N  captured read data (MDR data_in).
- mdr_load  out  1  one-cycle load strobe (MDR load_enable).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- All outputs are registered.
- Reset values:
  - State = IDLE.
  - sram_ce_n = sram_oe_n = sram_we_n = 1.
  - sram_drive = 0, busy = 0, done = 0, mdr_load = 0.
  - sram_addr = 0, sram_dout = 0, mdr_data = 0.
  - Wait counter = 0.
- States: IDLE, RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE:
  - start_rd=1 at an edge: latch addr into sram_addr, counter = WAIT_CYCLES-1, go to RD_WAIT.
  - Else start_wr=1: latch addr into sram_addr and wdata into sram_dout, go to WR_SETUP.
  - If both are high, the read wins and the write request is dropped.
- RD_WAIT:
  - Outputs: ce_n=0, oe_n=0, we_n=1, drive=0.
  - Counter decrements each edge.
  - When counter==0, the edge captures sram_din into mdr_data and goes to DONE with mdr_load=1.
  - Occupies exactly WAIT_CYCLES cycles.
- WR_SETUP:
  - Outputs: ce_n=0, oe_n=1, we_n=1, drive=1.
  - One cycle; loads counter = WAIT_CYCLES-1.
- WR_PULSE:
  - Outputs: ce_n=0, we_n=0, drive=1.
  - Lasts WAIT_CYCLES cycles, then goes to WR_HOLD.
- WR_HOLD:
  - Outputs: ce_n=0, we_n=1, drive=1.
  - One cycle (data hold after the we_n rising edge), then goes to DONE.
- DONE:
  - Outputs: all strobes inactive, drive=0, done=1, busy=1.
  - mdr_load=1 only if the access was a read.
  - Always goes to IDLE next edge.
- Latency, with accept edge = E0:
  - Read: done high in cycle E0+WAIT_CYCLES+1.
  - Write: done high in cycle E0+WAIT_CYCLES+3.
- Back-to-back: requests are accepted only in IDLE. A start held high continuously starts the next access at the edge ending the IDLE cycle that follows DONE, so there is exactly one idle cycle between accesses.
- Data stability:
  - addr and wdata changes while busy have no effect; latched values are used.
  - mdr_data holds its value until the next read capture; writes never modify it.
- Strobe rules:
  - sram_we_n and sram_oe_n are never low in the same cycle.
  - sram_drive=0 whenever oe_n=0.
- Reset mid-operation: the next edge forces the IDLE reset values. No done or mdr_load pulse is emitted for the aborted access. An aborted write may leave the SRAM word undefined.
- Reset has priority over start in the same cycle.

Optional Feature:
- Macro: MEM_IO_MAP_EN.
- When defined, add these ports:
  - sw_in  in  N  switch inputs.
  - hex_out  out  N  display register; reset value 0.
- With the macro defined, address 16'hFFFF is I/O-mapped:
  - Read: skips the SRAM (all strobes stay inactive). mdr_data = sw_in captured at the accept edge. Goes IDLE→DONE directly, so done arrives in cycle E0+1.
  - Write: skips the SRAM. hex_out = wdata at the accept edge. Goes to DONE directly.
- Without the macro: no extra ports, and 16'hFFFF is an ordinary SRAM address.

Test Plan:
- Reset, then idle 3 cycles -> all strobes high, busy=0, done=0, mdr_data=0x0000.
- Read of addr=0x1234 (WAIT_CYCLES=2) with sram_din=0xBEEF:
  - ce_n/oe_n low for exactly 2 cycles with sram_addr=0x1234.
  - done and mdr_load high together in cycle E0+3.
  - mdr_data=0xBEEF.
- Write of addr=0x00A0, wdata=0x5A5A:
  - Cycle sequence: setup 1 cycle, we_n low 2 cycles, hold 1 cycle.
  - sram_dout=0x5A5A and drive=1 throughout.
  - done in cycle E0+5, mdr_load stays 0.
- start_rd and start_wr high together, then start_rd held high for 10 cycles:
  - Only reads occur.
  - Exactly one IDLE cycle between each done and the next ce_n fall.
- Reset asserted in the second WR_PULSE cycle -> next edge we_n=1, ce_n=1, busy=0, and no done pulse.
- With MEM_IO_MAP_EN:
  - Read 0xFFFF with sw_in=0x00C3 -> mdr_data=0x00C3, done at E0+1, ce_n never low.
  - Write 0xFFFF with 0x0042 -> hex_out=0x0042.
